// File: rtl/axi_excl_pkg.sv
// Shared types and encodings for the AXI exclusive-access initiator.
// States, response status codes, AXI response codes and LR/SC op encoding.
package axi_excl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_AR   = 3'd1;
  localparam state_t ST_R    = 3'd2;
  localparam state_t ST_WR   = 3'd3;
  localparam state_t ST_B    = 3'd4;
  localparam state_t ST_RSP  = 3'd5;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_SC_FAIL = 2'd1,
    RSP_BUS_ERR = 2'd2,
    RSP_NO_EXCL = 2'd3
  } rsp_status_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic OP_LR = 1'b0;
  localparam logic OP_SC = 1'b1;

endpackage

// File: rtl/axi_excl_initiator_res_reg.sv
// Single-entry local reservation: granule-aligned address plus valid bit.
// Set wins over clear when both are requested in the same cycle.
module axi_excl_res_reg #(
  parameter int unsigned AW = 64,
  parameter int unsigned G  = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          set_i,
  input  logic          clr_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic [AW-1:0] cmp_addr_i,
  output logic          match_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;

  // Next reservation contents
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (clr_i) valid_d = 1'b0;
    if (set_i) begin
      valid_d = 1'b1;
      addr_d  = {set_addr_i[AW-1:G], {G{1'b0}}};
    end
  end

  // Reservation state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign match_o = valid_q &&
    (cmp_addr_i[AW-1:G] == addr_q[AW-1:G]);

endmodule

// File: rtl/axi_excl_initiator.sv
// LR/SC to single-beat AXI exclusive read/write initiator.
// Optional AXI_EXCL_LOCAL_FAIL_EN: fail SCs locally without a reservation.
import axi_excl_pkg::*;

module axi_excl_initiator #(
  parameter int unsigned AXI_ADDR_WIDTH   = 64,
  parameter int unsigned AXI_DATA_WIDTH   = 64,
  parameter int unsigned AXI_ID_WIDTH     = 4,
  parameter int unsigned AXI_ID           = 0,
  parameter int unsigned RES_GRANULE_LOG2 = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_op_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]                  req_size_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]                  rsp_status_o,
  output logic [AXI_ADDR_WIDTH-1:0]   ax_addr_o,
  output logic [2:0]                  ax_size_o,
  output logic [AXI_ID_WIDTH-1:0]     ax_id_o,
  output logic                        ax_lock_o,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  input  logic                        r_valid_i,
  output logic                        r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                  r_resp_i,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  input  logic [1:0]                  b_resp_i
);

  localparam int unsigned DW = AXI_DATA_WIDTH;
  localparam int unsigned SW = AXI_DATA_WIDTH / 8;
  localparam logic [DW-1:0] RD_ONE = {{(DW-1){1'b0}}, 1'b1};

  state_t                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]                  size_q, size_d;
  logic [DW-1:0]               wdata_q, wdata_d;
  logic [SW-1:0]               strb_q, strb_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic [DW-1:0]               rdata_q, rdata_d;
  logic [1:0]                  status_q, status_d;
  logic                        res_set, res_clr;

`ifdef AXI_EXCL_LOCAL_FAIL_EN
  logic res_match;
`endif

  axi_excl_res_reg #(
    .AW (AXI_ADDR_WIDTH),
    .G  (RES_GRANULE_LOG2)
  ) u_res (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (res_set),
    .clr_i      (res_clr),
    .set_addr_i (addr_q),
    .cmp_addr_i (req_addr_i),
`ifdef AXI_EXCL_LOCAL_FAIL_EN
    .match_o    (res_match)
`else
    .match_o    ()
`endif
  );

  // Transaction sequencing and response capture
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    res_set   = 1'b0;
    res_clr   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          size_d    = req_size_i;
          wdata_d   = req_wdata_i;
          strb_d    = req_strb_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (req_op_i == OP_LR) begin
            state_d = ST_AR;
          end else begin
`ifdef AXI_EXCL_LOCAL_FAIL_EN
            if (res_match) begin
              state_d = ST_WR;
            end else begin
              state_d  = ST_RSP;
              status_d = RSP_SC_FAIL;
              rdata_d  = RD_ONE;
              res_clr  = 1'b1;
            end
`else
            state_d = ST_WR;
`endif
          end
        end
      end
      ST_AR: begin
        if (ar_ready_i) state_d = ST_R;
      end
      ST_R: begin
        if (r_valid_i) begin
          state_d = ST_RSP;
          rdata_d = r_data_i;
          unique case (r_resp_i)
            AXI_RESP_EXOKAY: begin
              status_d = RSP_OK;
              res_set  = 1'b1;
            end
            AXI_RESP_OKAY: begin
              status_d = RSP_NO_EXCL;
              res_clr  = 1'b1;
            end
            default: begin
              status_d = RSP_BUS_ERR;
              res_clr  = 1'b1;
            end
          endcase
        end
      end
      ST_WR: begin
        aw_done_d = aw_done_q | aw_ready_i;
        w_done_d  = w_done_q | w_ready_i;
        if (aw_done_d && w_done_d) state_d = ST_B;
      end
      ST_B: begin
        if (b_valid_i) begin
          state_d = ST_RSP;
          res_clr = 1'b1;
          unique case (b_resp_i)
            AXI_RESP_EXOKAY: begin
              status_d = RSP_OK;
              rdata_d  = '0;
            end
            AXI_RESP_OKAY: begin
              status_d = RSP_SC_FAIL;
              rdata_d  = RD_ONE;
            end
            default: begin
              status_d = RSP_BUS_ERR;
              rdata_d  = RD_ONE;
            end
          endcase
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched request/response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign rsp_valid_o  = (state_q == ST_RSP);
  assign rsp_rdata_o  = rdata_q;
  assign rsp_status_o = status_q;
  assign ax_addr_o    = addr_q;
  assign ax_size_o    = size_q;
  assign ax_id_o      = AXI_ID_WIDTH'(AXI_ID);
  assign ax_lock_o    = 1'b1;
  assign ar_valid_o   = (state_q == ST_AR);
  assign r_ready_o    = (state_q == ST_R);
  assign aw_valid_o   = (state_q == ST_WR) && !aw_done_q;
  assign w_valid_o    = (state_q == ST_WR) && !w_done_q;
  assign w_data_o     = wdata_q;
  assign w_strb_o     = strb_q;
  assign b_ready_o    = (state_q == ST_B);

endmodule
